// File: rtl/pipelined_adder_pkg.sv
// Shared parameters, elaboration helpers and stage record for the pipelined adder.
// Flat-bus offset helpers let the top pack per-stage vectors of varying width.
package pipelined_adder_pkg;

  localparam int unsigned MaxStages = 16;

  typedef struct packed {
    logic valid;
    logic carry;
  } stage_ctrl_t;

  function automatic int unsigned calc_stages(input int unsigned width, input int unsigned chunk);
    return (chunk == 0) ? 0 : width / chunk;
  endfunction

  function automatic bit cfg_ok(input int unsigned width, input int unsigned chunk);
    return (chunk != 0) && (width % chunk == 0) && (width / chunk >= 1) &&
           (width / chunk <= MaxStages);
  endfunction

  // Stage k keeps operand bits [width-1:(k+1)*chunk]; offsets stack these upward.
  function automatic int unsigned rem_offset(input int unsigned width, input int unsigned chunk,
                                             input int unsigned k);
    int unsigned off;
    off = 0;
    for (int unsigned j = 0; j < k; j++) off += width - (j + 1) * chunk;
    return off;
  endfunction

  // Stage k keeps sum bits [(k+1)*chunk-1:0].
  function automatic int unsigned sum_offset(input int unsigned chunk, input int unsigned k);
    return chunk * k * (k + 1) / 2;
  endfunction

endpackage

// File: rtl/pipelined_adder_slice.sv
// Combinational CHUNK-bit ripple adder built from per-bit full-adder equations.
// Also reports the carry into its top bit for signed-overflow detection.
module pipelined_adder_slice #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] i_a,
  input  logic [CHUNK-1:0] i_b,
  input  logic             i_cin,
  output logic [CHUNK-1:0] o_sum,
  output logic             o_cout,
  output logic             o_c_top
);

  always_comb begin
    logic c;
    c       = i_cin;
    o_sum   = '0;
    o_c_top = i_cin;
    for (int i = 0; i < CHUNK; i++) begin
      o_c_top  = c;
      o_sum[i] = i_a[i] ^ i_b[i] ^ c;
      c        = (i_a[i] & i_b[i]) | (c & (i_a[i] ^ i_b[i]));
    end
    o_cout = c;
  end

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined ripple-carry adder: one CHUNK-bit slice and one register stage per slice,
// valid/ready flow control with bubble collapse.
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned STAGES  = calc_stages(WIDTH, CHUNK);
  localparam int unsigned RemBits = (STAGES > 1) ? rem_offset(WIDTH, CHUNK, STAGES - 1) : 1;
  localparam int unsigned SumBits = sum_offset(CHUNK, STAGES);

  if (!cfg_ok(WIDTH, CHUNK)) begin : g_cfg_err
    $error("pipelined_adder: WIDTH must be a multiple of CHUNK giving 1..16 stages");
  end

  logic [STAGES-1:0]  w_valid;
  logic [STAGES-1:0]  w_carry;
  logic [STAGES-1:0]  w_load;
  logic [RemBits-1:0] w_rem_a;
  logic [RemBits-1:0] w_rem_b;
  logic [SumBits-1:0] w_sum_bus;
  logic               w_msb_carry;

  // Load chain runs back to front so a drain at the output frees every stage behind it.
  always_comb begin
    logic v_drain;
    w_load  = '0;
    v_drain = w_valid[STAGES-1] && out_ready;
    for (int k = STAGES - 1; k > 0; k--) begin
      w_load[k] = !w_valid[k] || v_drain;
      v_drain   = w_valid[k-1] && w_load[k];
    end
    w_load[0] = !w_valid[0] || v_drain;
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int unsigned SumW   = (k + 1) * CHUNK;
    localparam int unsigned SumOff = sum_offset(CHUNK, k);

    logic [CHUNK-1:0] w_op_a;
    logic [CHUNK-1:0] w_op_b;
    logic [CHUNK-1:0] w_chunk_sum;
    logic             w_cin;
    logic             w_up_valid;
    logic             w_chunk_cout;
    logic             w_chunk_ctop;
    logic [SumW-1:0]  w_sum_next;
    stage_ctrl_t      r_ctrl;
    logic [SumW-1:0]  r_sum;

    if (k == 0) begin : g_head
      assign w_op_a     = a[CHUNK-1:0];
      assign w_op_b     = b[CHUNK-1:0];
      assign w_cin      = cin;
      assign w_up_valid = in_valid;
      assign w_sum_next = w_chunk_sum;
    end else begin : g_body
      localparam int unsigned PrevRemOff = rem_offset(WIDTH, CHUNK, k - 1);
      localparam int unsigned PrevSumOff = sum_offset(CHUNK, k - 1);
      assign w_op_a     = w_rem_a[PrevRemOff +: CHUNK];
      assign w_op_b     = w_rem_b[PrevRemOff +: CHUNK];
      assign w_cin      = w_carry[k-1];
      assign w_up_valid = w_valid[k-1];
      assign w_sum_next = {w_chunk_sum, w_sum_bus[PrevSumOff +: k * CHUNK]};
    end

    pipelined_adder_slice #(
      .CHUNK(CHUNK)
    ) u_slice (
      .i_a    (w_op_a),
      .i_b    (w_op_b),
      .i_cin  (w_cin),
      .o_sum  (w_chunk_sum),
      .o_cout (w_chunk_cout),
      .o_c_top(w_chunk_ctop)
    );

    // Data only moves with a valid entry, so bubbles never disturb the held result.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_ctrl <= '0;
        r_sum  <= '0;
      end else if (w_load[k]) begin
        r_ctrl.valid <= w_up_valid;
        if (w_up_valid) begin
          r_ctrl.carry <= w_chunk_cout;
          r_sum        <= w_sum_next;
        end
      end
    end

    assign w_valid[k]                  = r_ctrl.valid;
    assign w_carry[k]                  = r_ctrl.carry;
    assign w_sum_bus[SumOff +: SumW]   = r_sum;

    if (k < STAGES - 1) begin : g_rem
      localparam int unsigned RemW   = WIDTH - SumW;
      localparam int unsigned RemOff = rem_offset(WIDTH, CHUNK, k);

      logic [RemW-1:0] w_rem_a_next;
      logic [RemW-1:0] w_rem_b_next;
      logic [RemW-1:0] r_rem_a;
      logic [RemW-1:0] r_rem_b;

      if (k == 0) begin : g_from_port
        assign w_rem_a_next = a[WIDTH-1:CHUNK];
        assign w_rem_b_next = b[WIDTH-1:CHUNK];
      end else begin : g_from_prev
        localparam int unsigned PrevRemOff = rem_offset(WIDTH, CHUNK, k - 1);
        assign w_rem_a_next = w_rem_a[PrevRemOff + CHUNK +: RemW];
        assign w_rem_b_next = w_rem_b[PrevRemOff + CHUNK +: RemW];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_rem_a <= '0;
          r_rem_b <= '0;
        end else if (w_load[k] && w_up_valid) begin
          r_rem_a <= w_rem_a_next;
          r_rem_b <= w_rem_b_next;
        end
      end

      assign w_rem_a[RemOff +: RemW] = r_rem_a;
      assign w_rem_b[RemOff +: RemW] = r_rem_b;
    end else begin : g_tail
      logic r_c_top;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_c_top <= 1'b0;
        end else if (w_load[k] && w_up_valid) begin
          r_c_top <= w_chunk_ctop;
        end
      end

      assign w_msb_carry = r_c_top;
    end
  end

  assign in_ready  = w_load[0];
  assign out_valid = w_valid[STAGES-1];
  assign cout      = w_carry[STAGES-1];
  assign sum       = w_sum_bus[SumBits-1 -: WIDTH];
  assign ovf       = cout ^ w_msb_carry;

endmodule
